pipeline_hazard_controller: RTL

Sequences the ID/EX pipeline register and its neighbours in the 16-bit five-stage processor. It detects load-use hazards, taken branches resolved in MEM, and multi-cycle data-memory waits. It issues hold, bubble, flush and freeze controls to the PC, IF/ID, ID/EX and EX/MEM registers. Decisions are registered on the rising edge and consumed by the pipeline registers on the following falling edge.

---
 rtl/pipeline_hazard_controller.sv | 158 +++++++++++++++
 1 files changed

// File: rtl/pipeline_hazard_controller.sv
// ---------------------------------------------------------------------------
// pipeline_hazard_controller
//
// Hazard sequencer for the 16-bit five-stage pipeline. It watches the ID/EX
// and IF/ID registers for load-use hazards, the EX/MEM register for taken
// branches, and the data memory for multi-cycle accesses. It then issues
// hold / bubble / flush / freeze controls to the PC, IF/ID, ID/EX and EX/MEM
// registers.
//
// The controller updates on the rising edge. Every control output is a Moore
// decode of the registered state, so the pipeline registers (which update on
// the falling edge) always see values that were stable for half a cycle.
//
// Parameters:
//   FLUSH_CYCLES  cycles spent in FLUSH per taken branch (1..7)
//   CNT_WIDTH     width of the saturating stall-cycle counter
//
// Ports:
//   clock             system clock (controller uses posedge)
//   reset             synchronous, active-high
//   idexMemRead       MemRead control held in ID/EX
//   idexRt            rt (destination) field held in ID/EX
//   ifidRs            rs field of the instruction in IF/ID
//   ifidRt            rt field of the instruction in IF/ID
//   ifidUsesRt        IF/ID instruction reads rt as a source
//   exmemBranchTaken  branch in EX/MEM resolved taken
//   memBusy           data memory access still in progress
//   PCWrite           PC may load
//   IFIDWrite         IF/ID may load
//   bubble            zero all ID/EX control inputs
//   flushIFID         clear IF/ID to NOP
//   flushIDEX         clear ID/EX controls
//   flushEXMEM        clear EX/MEM controls
//   freeze            every pipeline register holds
//   state             current state (RUN=00 LOADSTALL=01 FLUSH=10 MEMWAIT=11)
//   stallCycles       saturating count of non-RUN cycles
// ---------------------------------------------------------------------------
module pipeline_hazard_controller #(
    parameter int FLUSH_CYCLES = 1,
    parameter int CNT_WIDTH    = 16
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 idexMemRead,
    input  logic [2:0]           idexRt,
    input  logic [2:0]           ifidRs,
    input  logic [2:0]           ifidRt,
    input  logic                 ifidUsesRt,
    input  logic                 exmemBranchTaken,
    input  logic                 memBusy,
    output logic                 PCWrite,
    output logic                 IFIDWrite,
    output logic                 bubble,
    output logic                 flushIFID,
    output logic                 flushIDEX,
    output logic                 flushEXMEM,
    output logic                 freeze,
    output logic [1:0]           state,
    output logic [CNT_WIDTH-1:0] stallCycles
);

    localparam logic [1:0] RUN       = 2'b00;
    localparam logic [1:0] LOADSTALL = 2'b01;
    localparam logic [1:0] FLUSH     = 2'b10;
    localparam logic [1:0] MEMWAIT   = 2'b11;

    // Counter value on FLUSH entry: the entry cycle itself is the first of
    // FLUSH_CYCLES, so the counter covers the remaining ones.
    localparam logic [2:0] FLUSH_LOAD = 3'(FLUSH_CYCLES - 1);

    logic [1:0] nextState;
    logic [2:0] flushCnt;
    logic [2:0] nextFlushCnt;
    logic       loadUse;
    logic       evalEnable;

    // No register-0 exclusion: r0 hazards stall like any other register.
    assign loadUse = idexMemRead &
                     ((idexRt == ifidRs) | (ifidUsesRt & (idexRt == ifidRt)));

    // FLUSH is uninterruptible until its counter drains; every other state
    // re-evaluates each cycle.
    assign evalEnable = (state != FLUSH) || (flushCnt == 3'd0);

    // ---------------------------------------------------------------- state
    always_ff @(posedge clock) begin
        if (reset) begin
            state    <= RUN;
            flushCnt <= 3'd0;
        end else begin
            state    <= nextState;
            flushCnt <= nextFlushCnt;
        end
    end

    // Counts edges at which the pipeline was not running, i.e. the cycles
    // that just ended in a non-RUN state. Saturates instead of wrapping.
    always_ff @(posedge clock) begin
        if (reset) begin
            stallCycles <= '0;
        end else if ((state != RUN) && (stallCycles != {CNT_WIDTH{1'b1}})) begin
            stallCycles <= stallCycles + CNT_WIDTH'(1);
        end
    end

    // ----------------------------------------------------------- next state
    always_comb begin
        nextState    = state;
        nextFlushCnt = 3'd0;
        if (!evalEnable) begin
            nextState    = FLUSH;
            nextFlushCnt = flushCnt - 3'd1;
        end else if (memBusy) begin
            // Freeze wins: a pending branch or hazard is still sitting in the
            // frozen registers and gets picked up when memory finishes.
            nextState = MEMWAIT;
        end else if (exmemBranchTaken) begin
            // Branch beats load-use: flushing ID/EX discards the load anyway.
            nextState    = FLUSH;
            nextFlushCnt = FLUSH_LOAD;
        end else if (loadUse) begin
            nextState = LOADSTALL;
        end else begin
            nextState = RUN;
        end
    end

    // -------------------------------------------------------------- outputs
    always_comb begin
        PCWrite    = 1'b0;
        IFIDWrite  = 1'b0;
        bubble     = 1'b0;
        flushIFID  = 1'b0;
        flushIDEX  = 1'b0;
        flushEXMEM = 1'b0;
        freeze     = 1'b0;
        case (state)
            RUN: begin
                PCWrite   = 1'b1;
                IFIDWrite = 1'b1;
            end
            LOADSTALL: begin
                bubble = 1'b1;
            end
            FLUSH: begin
                PCWrite    = 1'b1;
                IFIDWrite  = 1'b1;
                flushIFID  = 1'b1;
                flushIDEX  = 1'b1;
                flushEXMEM = 1'b1;
            end
            default: begin
                freeze = 1'b1;
            end
        endcase
    end

endmodule
